mano_seq_ctrl: RTL and testbench

Sequence controller for the Mano CPU timing chain. It consumes the step count `t` from the sequence counter and drives that counter's clear and enable. It also decodes `t` into one-hot timing signals T0..Tn, and sequences the instruction cycle, the interrupt cycle (R flip-flop) and the halt state. An optional checker cross-validates the counter against an internal shadow count for fault detection.

---
 rtl/mano_seq_ctrl_if.sv | 31 +++
 rtl/mano_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_mano_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mano_seq_ctrl_if.sv
// Handshake bundle between the Mano sequence controller and the rest of the CPU
// (sequence counter, datapath, interrupt logic).
interface mano_seq_ctrl_if #(
  parameter int SEQW = 4
);
  logic [SEQW-1:0]        t;
  logic                   start;
  logic                   exec_done;
  logic                   hlt;
  logic                   ien;
  logic                   irq;
  logic                   sc_en;
  logic                   sc_clr;
  logic [(1<<SEQW)-1:0]   tdec;
  logic                   r_flag;
  logic                   ien_clr;
  logic                   halted;
  logic                   fault;

  // CPU side: owns the counter and the datapath, consumes the timing signals
  modport master (
    output t, start, exec_done, hlt, ien, irq,
    input  sc_en, sc_clr, tdec, r_flag, ien_clr, halted, fault
  );

  // controller side
  modport slave (
    input  t, start, exec_done, hlt, ien, irq,
    output sc_en, sc_clr, tdec, r_flag, ien_clr, halted, fault
  );
endinterface

// File: rtl/mano_seq_ctrl.sv
// Mano CPU sequence controller: drives the sequence counter clear/enable,
// decodes t into one-hot T0..Tn and walks HALT -> RUN -> INTR.
// Optional build macro MANO_SEQ_CHECK_EN adds a shadow counter and a
// step watchdog that raise a sticky fault and force HALT.
module mano_seq_ctrl #(
  parameter int SEQW     = 4,
  parameter int STEP_MAX = 7
) (
  input logic            clk,
  input logic            rst,
  mano_seq_ctrl_if.slave bus
);
  localparam int TW = 1 << SEQW;

  // STEP_MAX has to be a reachable step value
  if (STEP_MAX < 0 || STEP_MAX >= TW) begin : g_bad_step_max
    $error("mano_seq_ctrl: STEP_MAX out of range for SEQW");
  end

  typedef enum logic [1:0] {S_HALT, S_RUN, S_INTR} state_e;

  state_e          state_q, state_d;
  logic            r_q, r_d;
  logic            fault_q;
  logic            trip;
  logic            rset;
  logic            sc_en, sc_clr, ien_clr;
  logic [TW-1:0]   tdec;

`ifdef MANO_SEQ_CHECK_EN
  logic [SEQW-1:0] sh_q, sh_d;

  // shadow count tracks what the real counter must show; watchdog bounds RUN steps
  always_comb begin
    sh_d = sh_q;
    if (sc_clr)     sh_d = '0;
    else if (sc_en) sh_d = sh_q + SEQW'(1);
    trip = ((state_q != S_HALT) && (bus.t != sh_q)) ||
           ((state_q == S_RUN) && (bus.t == SEQW'(STEP_MAX)) &&
            !bus.exec_done && !bus.hlt);
  end

  // shadow counter and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      fault_q <= fault_q | trip;
    end
  end
`else
  assign trip    = 1'b0;
  assign fault_q = 1'b0;
`endif

  // next state, R flip-flop and counter control
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    sc_en   = 1'b0;
    sc_clr  = 1'b0;
    ien_clr = 1'b0;
    tdec    = '0;
    rset    = (bus.t >= SEQW'(3)) && bus.ien && bus.irq;
    case (state_q)
      S_HALT: begin
        sc_clr = 1'b1;
        if (bus.start && !fault_q) state_d = S_RUN;
      end
      S_RUN: begin
        tdec[bus.t] = 1'b1;
        if (bus.hlt) begin
          // halting wins over a pending or newly raised interrupt
          sc_clr  = 1'b1;
          state_d = S_HALT;
          r_d     = 1'b0;
        end else begin
          if (rset) r_d = 1'b1;
          if (bus.exec_done) begin
            sc_clr = 1'b1;
            if (r_q || rset) state_d = S_INTR;
          end else begin
            sc_en = 1'b1;
          end
        end
      end
      S_INTR: begin
        tdec[bus.t] = 1'b1;
        if (bus.t == SEQW'(2)) begin
          sc_clr  = 1'b1;
          ien_clr = 1'b1;
          r_d     = 1'b0;
          state_d = S_RUN;
        end else begin
          sc_en = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
    // a detected counter fault stops the machine at the same edge
    if (trip) begin
      state_d = S_HALT;
      r_d     = 1'b0;
    end
  end

  // state and R flip-flop registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HALT;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  assign bus.sc_en   = sc_en;
  assign bus.sc_clr  = sc_clr;
  assign bus.tdec    = tdec;
  assign bus.ien_clr = ien_clr;
  assign bus.r_flag  = r_q;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.fault   = fault_q;
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Bench for mano_seq_ctrl: the bench owns the sequence counter, drives directed
// and random traffic, and compares every cycle against a behavioural model.
module tb_mano_seq_ctrl;
`ifdef MANO_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic cap_clr = 1'b0;
  logic cap_en  = 1'b0;

  // model: mode 0 = halted, 1 = running an instruction, 2 = interrupt cycle
  int         m_mode = 0;
  logic       m_r    = 1'b0;
  logic       m_f    = 1'b0;
  logic [3:0] m_sh   = 4'd0;

  mano_seq_ctrl_if #(.SEQW(4)) bus ();

  mano_seq_ctrl #(.SEQW(4), .STEP_MAX(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d time=%0t)", nm, act, exp, bus.t, $time);
    end
  endtask

  // model and per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    logic        e_clr, e_en, e_iclr, bnd, want, trip;
    logic [15:0] e_tdec;
    if (rst) begin
      m_mode = 0; m_r = 1'b0; m_f = 1'b0; m_sh = 4'd0;
    end
    e_iclr = 1'b0;
    e_tdec = (m_mode == 0) ? 16'h0 : (16'h1 << bus.t);
    if (m_mode == 0) begin
      e_clr = 1'b1; e_en = 1'b0;
    end else if (m_mode == 1) begin
      bnd   = bus.hlt || bus.exec_done;
      e_clr = bnd; e_en = !bnd;
    end else begin
      e_clr  = (bus.t == 4'd2);
      e_en   = !e_clr;
      e_iclr = e_clr;
    end
    chk("sc_clr",  bus.sc_clr,  e_clr);
    chk("sc_en",   bus.sc_en,   e_en);
    chk("tdec",    bus.tdec,    e_tdec);
    chk("ien_clr", bus.ien_clr, e_iclr);
    chk("r_flag",  bus.r_flag,  m_r);
    chk("halted",  bus.halted,  m_mode == 0);
    chk("fault",   bus.fault,   m_f);
    cap_clr = bus.sc_clr;
    cap_en  = bus.sc_en;
    if (!rst) begin
      trip = CHK && (((m_mode != 0) && (bus.t != m_sh)) ||
                     ((m_mode == 1) && (bus.t == 4'd7) && !bus.exec_done && !bus.hlt));
      m_sh = e_clr ? 4'd0 : (e_en ? m_sh + 4'd1 : m_sh);
      case (m_mode)
        0: if (bus.start && !m_f) m_mode = 1;
        1: begin
          want = (bus.t >= 4'd3) && bus.ien && bus.irq;
          if (bus.hlt) begin
            m_mode = 0; m_r = 1'b0;
          end else begin
            if (want) m_r = 1'b1;
            if (bus.exec_done) m_mode = m_r ? 2 : 1;
          end
        end
        default: if (bus.t == 4'd2) begin m_mode = 1; m_r = 1'b0; end
      endcase
      if (trip) begin
        m_f = 1'b1; m_mode = 0; m_r = 1'b0;
      end
    end
  end

  // advance one clock; the bench's counter reacts to last cycle's controls
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.t = cap_clr ? 4'd0 : (cap_en ? bus.t + 4'd1 : bus.t);
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic clr_in();
    bus.start = 1'b0; bus.exec_done = 1'b0; bus.hlt = 1'b0;
    bus.ien = 1'b0; bus.irq = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int t2[9], r2[9], ic2[9];
    int t3[7], h3[7];
    bus.t = 4'd0;
    clr_in();
    do_reset();

    // reset state
    cyc();
    settle();
    chk("rst_halted", bus.halted, 1);
    chk("rst_sc_clr", bus.sc_clr, 1);
    chk("rst_sc_en",  bus.sc_en,  0);
    chk("rst_tdec",   bus.tdec,   0);
    chk("rst_r",      bus.r_flag, 0);
    chk("rst_fault",  bus.fault,  0);

    // instruction with exec_done at t=5
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) cyc();
      bus.exec_done = (bus.t == 4'd5);
      settle();
      chk("s1_t",     bus.t,      (i == 6) ? 0 : i);
      chk("s1_tdec",  bus.tdec,   (i == 6) ? 32'h1 : (32'h1 << i));
      chk("s1_sc_clr", bus.sc_clr, i == 5);
    end

    // interrupt raised at t=3, instruction ends at t=4
    t2  = '{0, 1, 2, 3, 4, 0, 1, 2, 0};
    r2  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    ic2 = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc();
      bus.ien = 1'b1;
      bus.irq = (k == 3);
      bus.exec_done = (k == 4);
      settle();
      chk("s2_t",       bus.t,       t2[k]);
      chk("s2_r",       bus.r_flag,  r2[k]);
      chk("s2_ien_clr", bus.ien_clr, ic2[k]);
      chk("s2_halted",  bus.halted,  0);
    end

    // hlt together with exec_done and an interrupt request at t=3
    t3 = '{1, 2, 3, 0, 0, 0, 0};
    h3 = '{0, 0, 0, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      cyc();
      clr_in();
      if (k == 2) begin
        bus.hlt = 1'b1; bus.exec_done = 1'b1; bus.ien = 1'b1; bus.irq = 1'b1;
      end
      bus.start = (k == 5);
      settle();
      chk("s3_t",      bus.t,      t3[k]);
      chk("s3_halted", bus.halted, h3[k]);
      chk("s3_r",      bus.r_flag, 0);
    end

    // counter mismatch: t forced to 6 where the shadow count is 2
    do_reset();
    clr_in();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    bus.t = 4'd6;
    settle();
    cyc();
    settle();
    chk("mm_fault",  bus.fault,  CHK);
    chk("mm_halted", bus.halted, CHK);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    settle();
    chk("mm_start_blocked", bus.halted, CHK);

    // watchdog: correct counter, no exec_done, t climbs to 7
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    settle();
    chk("wd_t7", bus.t, 7);
    cyc();
    settle();
    chk("wd_fault",  bus.fault,  CHK);
    chk("wd_halted", bus.halted, CHK);

    // random traffic with occasional counter glitches and resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst           = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) bus.t = 4'($urandom);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.exec_done = ($urandom_range(0, 3) == 0);
      bus.hlt       = ($urandom_range(0, 29) == 0);
      bus.ien       = 1'($urandom);
      bus.irq       = ($urandom_range(0, 2) == 0);
    end
    cyc();
    rst = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
